// File: rtl/niosii_multi_interval_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
// Address is {channel, reg[2:0]}; readdata and irq come back from the timer.
interface niosii_multi_interval_timer_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int AW = $clog2(NUM_CH) + 3;

    logic [AW-1:0]    address;
    logic             chipselect;
    logic             write_n;
    logic [CNT_W-1:0] writedata;
    logic [CNT_W-1:0] readdata;
    logic             irq;

    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/niosii_multi_interval_timer.sv
// NUM_CH independent prescaled down-counters with timeout flags, snapshot capture,
// a pending bitmap and one ORed, registered irq.
module niosii_mit_channel #(
    parameter int CNT_W        = 32,
    parameter int PRE_W        = 8,
    parameter int RESET_PERIOD = 49999
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             sel_i,
    input  logic [2:0]       reg_i,
    input  logic [CNT_W-1:0] wdata_i,
    output logic             to_o,
    output logic             run_o,
    output logic             ito_o,
    output logic             cont_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] snap_o,
    output logic [PRE_W-1:0] pre_o
);
    logic             to_q, to_d, run_q, run_d, ito_q, ito_d, cont_q, cont_d;
    logic [CNT_W-1:0] period_q, period_d, cnt_q, cnt_d, snap_q, snap_d;
    logic [PRE_W-1:0] pre_q, pre_d, pcnt_q, pcnt_d;
    logic             wr_sts, wr_ctl, wr_per, wr_snap, wr_pre, tick;

    assign wr_sts  = sel_i && (reg_i == 3'd0);
    assign wr_ctl  = sel_i && (reg_i == 3'd1);
    assign wr_per  = sel_i && (reg_i == 3'd2);
    assign wr_snap = sel_i && (reg_i == 3'd3);
    assign wr_pre  = sel_i && (reg_i == 3'd4);
    // >= keeps the prescaler from running the long way round if PRESCALE shrinks mid-count
    assign tick    = run_q && (pcnt_q >= pre_q);

    always_comb begin
        to_d     = to_q;
        run_d    = run_q;
        ito_d    = ito_q;
        cont_d   = cont_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        pre_d    = pre_q;
        if (!run_q || wr_per || tick) pcnt_d = '0;
        else                          pcnt_d = pcnt_q + PRE_W'(1);
        if (wr_sts) to_d = 1'b0;
        if (tick) begin
            if (cnt_q == '0) begin
                to_d  = 1'b1;
                cnt_d = period_q;
                run_d = cont_q;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        if (wr_snap) snap_d = cnt_q;
        if (wr_ctl) begin
            ito_d  = wdata_i[0];
            cont_d = wdata_i[1];
            if (wdata_i[3])      run_d = 1'b0;
            else if (wdata_i[2]) run_d = 1'b1;
        end
        // a PERIOD write lands after the tick so a coincident reload takes the new value
        if (wr_per) begin
            period_d = wdata_i;
            cnt_d    = wdata_i;
            run_d    = 1'b0;
        end
        if (wr_pre) pre_d = wdata_i[PRE_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            to_q     <= 1'b0;
            run_q    <= 1'b0;
            ito_q    <= 1'b0;
            cont_q   <= 1'b0;
            period_q <= CNT_W'(RESET_PERIOD);
            cnt_q    <= CNT_W'(RESET_PERIOD);
            snap_q   <= '0;
            pre_q    <= '0;
            pcnt_q   <= '0;
        end else begin
            to_q     <= to_d;
            run_q    <= run_d;
            ito_q    <= ito_d;
            cont_q   <= cont_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            pre_q    <= pre_d;
            pcnt_q   <= pcnt_d;
        end
    end

    assign to_o     = to_q;
    assign run_o    = run_q;
    assign ito_o    = ito_q;
    assign cont_o   = cont_q;
    assign period_o = period_q;
    assign snap_o   = snap_q;
    assign pre_o    = pre_q;
endmodule

module niosii_multi_interval_timer #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int PRE_W        = 8,
    parameter int RESET_PERIOD = 49999
) (
    input  logic                          clk,
    input  logic                          reset_n,
    niosii_multi_interval_timer_if.slave  bus
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                          we;
    logic [31:0]                   ch_sel;
    logic [CHW-1:0]                ch_idx;
    logic [2:0]                    reg_sel;
    logic [NUM_CH-1:0]             to_v, run_v, ito_v, cont_v, pend;
    logic [NUM_CH-1:0][CNT_W-1:0]  period_v, snap_v;
    logic [NUM_CH-1:0][PRE_W-1:0]  pre_v;
    logic [CNT_W-1:0]              rd_q, rd_d;
    logic                          irq_q, irq_d;

    assign we      = bus.chipselect && !bus.write_n;
    assign ch_sel  = 32'(bus.address) >> 3;
    assign ch_idx  = ch_sel[CHW-1:0];
    assign reg_sel = bus.address[2:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        niosii_mit_channel #(
            .CNT_W(CNT_W), .PRE_W(PRE_W), .RESET_PERIOD(RESET_PERIOD)
        ) u_ch (
            .clk_i    (clk),
            .reset_n_i(reset_n),
            .sel_i    (we && (ch_sel == 32'(i))),
            .reg_i    (reg_sel),
            .wdata_i  (bus.writedata),
            .to_o     (to_v[i]),
            .run_o    (run_v[i]),
            .ito_o    (ito_v[i]),
            .cont_o   (cont_v[i]),
            .period_o (period_v[i]),
            .snap_o   (snap_v[i]),
            .pre_o    (pre_v[i])
        );
    end

    assign pend  = to_v & ito_v;
    assign irq_d = |pend;

    always_comb begin
        rd_d = '0;
        if (ch_sel < 32'(NUM_CH)) begin
            case (reg_sel)
                3'd0:    rd_d = CNT_W'({run_v[ch_idx], to_v[ch_idx]});
                3'd1:    rd_d = CNT_W'({cont_v[ch_idx], ito_v[ch_idx]});
                3'd2:    rd_d = period_v[ch_idx];
                3'd3:    rd_d = snap_v[ch_idx];
                3'd4:    rd_d = CNT_W'(pre_v[ch_idx]);
                3'd5:    rd_d = CNT_W'(pend);
                default: rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            irq_q <= irq_d;
        end
    end

    assign bus.readdata = rd_q;
    assign bus.irq      = irq_q;
endmodule
